// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port,
// hard-wired zero at index 0, optional write-to-read bypass, and a committed-write counter.
module reg_file_32x32 #(
  parameter bit          BYPASS  = 1'b1,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite,
  input  logic [4:0]  write_register,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_register1,
  input  logic [4:0]  read_register2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [15:0] write_count
);

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wr_en;
  logic              commit;

  // One-hot write decode; index 0 never gets an enable, so it stays at its reset value of zero.
  always_comb begin
    wr_en = '0;
    if (RegWrite && (write_register != 5'd0))
      wr_en[write_register] = 1'b1;
  end

  assign commit = rst_n && (|wr_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      write_count <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wr_en[i]) regs[i] <= write_data;
      if (|wr_en) write_count <= write_count + 16'd1;
    end
  end

  // Bypass only forwards a write that will actually commit at the coming edge.
  always_comb begin
    if (read_register1 == 5'd0)
      read_data1 = '0;
    else if (BYPASS && commit && (write_register == read_register1))
      read_data1 = write_data;
    else
      read_data1 = regs[read_register1];
  end

  always_comb begin
    if (read_register2 == 5'd0)
      read_data2 = '0;
    else if (BYPASS && commit && (write_register == read_register2))
      read_data2 = write_data;
    else
      read_data2 = regs[read_register2];
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: a bypassing and a non-bypassing instance share all
// inputs; a reference model fills an expectation queue that is popped when outputs settle.
module tb_reg_file_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [15:0] cnt_b, cnt_n;

  always #5 clk = ~clk;

  reg_file_32x32 #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_register(write_register),
    .write_data(write_data), .read_register1(read_register1), .read_register2(read_register2),
    .read_data1(rd1_b), .read_data2(rd2_b), .write_count(cnt_b)
  );

  reg_file_32x32 #(.BYPASS(1'b0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_register(write_register),
    .write_data(write_data), .read_register1(read_register1), .read_register2(read_register2),
    .read_data1(rd1_n), .read_data2(rd2_n), .write_count(cnt_n)
  );

  typedef struct {
    string       tag;
    logic [31:0] e1_b, e2_b, e1_n, e2_n;
    logic [15:0] ecnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  logic [15:0] mdl_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp,
                                             input bit commit, input logic [4:0] wr,
                                             input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (byp && commit && wr == idx) return wd;
    return mdl[idx];
  endfunction

  // Drive one cycle at the falling edge, optionally check outputs before the rising edge,
  // then advance the model to the state after that rising edge.
  task automatic drive(input string tag, input logic rn, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input bit chk);
    exp_t e, got;
    bit   commit;
    @(negedge clk);
    rst_n = rn; RegWrite = we; write_register = wr; write_data = wd;
    read_register1 = r1; read_register2 = r2;
    commit = rn && we && (wr != 5'd0);
    if (chk) begin
      e.tag  = tag;
      e.e1_b = model_read(r1, 1'b1, commit, wr, wd);
      e.e2_b = model_read(r2, 1'b1, commit, wr, wd);
      e.e1_n = model_read(r1, 1'b0, commit, wr, wd);
      e.e2_n = model_read(r2, 1'b0, commit, wr, wd);
      e.ecnt = mdl_cnt;
      sb.push_back(e);
      #2;
      got = sb.pop_front();
      check({got.tag, "/byp_rd1"}, rd1_b, got.e1_b);
      check({got.tag, "/byp_rd2"}, rd2_b, got.e2_b);
      check({got.tag, "/nob_rd1"}, rd1_n, got.e1_n);
      check({got.tag, "/nob_rd2"}, rd2_n, got.e2_n);
      check({got.tag, "/byp_cnt"}, {16'h0, cnt_b}, {16'h0, got.ecnt});
      check({got.tag, "/nob_cnt"}, {16'h0, cnt_n}, {16'h0, got.ecnt});
    end
    if (!rn) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl[29] = 32'h0000_3FFC;
      mdl_cnt = 16'h0;
    end else if (commit) begin
      mdl[wr] = wd;
      mdl_cnt = mdl_cnt + 16'd1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; RegWrite = 1'b0; write_register = '0; write_data = '0;
    read_register1 = '0; read_register2 = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 'x;
    mdl_cnt = 'x;

    drive("rst", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    drive("after_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b1);

    drive("wr8", 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd3, 1'b1);
    drive("rd8", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1);

    drive("wr0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    drive("rd0", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0, 1'b1);

    drive("wr17a", 1'b1, 1'b1, 5'd17, 32'h0BAD_F00D, 5'd1, 5'd2, 1'b1);
    drive("bypass17", 1'b1, 1'b1, 5'd17, 32'h1234_5678, 5'd17, 5'd17, 1'b1);
    drive("rd17", 1'b1, 1'b0, 5'd17, 32'h0, 5'd17, 5'd8, 1'b1);

    drive("we0_hold", 1'b1, 1'b0, 5'd5, 32'h5555_5555, 5'd5, 5'd17, 1'b1);
    drive("we0_x", 1'b1, 1'b0, 5'd8, 'x, 5'd5, 5'd8, 1'b1);
    drive("rd_hold", 1'b1, 1'b0, 5'd8, 32'h0, 5'd5, 5'd8, 1'b1);

    drive("wr4_x", 1'b1, 1'b1, 5'd4, 'x, 5'd31, 5'd30, 1'b1);
    drive("rd4_x", 1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd31, 1'b1);

    drive("wr29", 1'b1, 1'b1, 5'd29, 32'h1111_2222, 5'd29, 5'd4, 1'b1);
    drive("rst_vs_wr", 1'b0, 1'b1, 5'd29, 32'hAAAA_AAAA, 5'd29, 5'd8, 1'b1);
    drive("after_rst2", 1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd8, 1'b1);

    drive("wr3", 1'b1, 1'b1, 5'd3, 32'hCAFE_0003, 5'd3, 5'd29, 1'b1);
    @(negedge clk);
    RegWrite = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive("glitch_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd29, 1'b1);

    drive("rst3", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 65536; i++)
      drive("wrap_wr", 1'b1, 1'b1, 5'd1, 32'h5A00_0000 | i, 5'd1, 5'd2, 1'b0);
    drive("wrap_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd29, 1'b1);
    check("wrap_cnt_zero", {16'h0, cnt_b}, 32'h0);
    check("wrap_last_val", rd1_b, 32'h5A00_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
